prio_arbiter_n: RTL and testbench

Registered, parametrised N-to-log2(N) priority encoder with a valid/ready output stage and a selectable round-robin mode. Generalises the 8-3 combinational priority encoder. Sits between N requesters and a single consumer: each accepted result names one requester (index plus one-hot). In round-robin mode no requester can be starved.

---
 rtl/prio_arb_pkg.sv | 13 +
 rtl/prio_enc_rot.sv | 48 ++++
 rtl/prio_arbiter_n.sv | 58 +++++
 tb/tb_prio_arbiter_n.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared constants and helpers for the parametrised priority arbiter.
// Mode encodings and the modulo-N pointer decrement used by the round-robin pointer.
package prio_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Wraps 0 to n-1 so non-power-of-two request counts never yield an index >= n.
  function automatic int ptr_dec(input int ptr, input int n);
    return (ptr == 0) ? (n - 1) : (ptr - 1);
  endfunction

endpackage

// File: rtl/prio_enc_rot.sv
// Combinational rotating priority encoder: descending search from 'start' with wrap-around.
// req is rotated so that an MSB-first encode finds the winner, then the position is un-rotated.
module prio_enc_rot #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] oh
);

  logic [N-1:0] rot;
  logic         hit;
  int           pos;
  int           src;

  // rot[N-1-k] holds requester (start-k) mod N, so the MSB of rot is the first one searched.
  always_comb begin
    rot   = '0;
    hit   = 1'b0;
    pos   = 0;
    src   = 0;
    found = 1'b0;
    idx   = '0;
    oh    = '0;
    for (int k = 0; k < N; k++) begin
      src = int'(start) - k;
      if (src < 0) src = src + N;
      rot[N-1-k] = req[src];
    end
    for (int k = 0; k < N; k++) begin
      if (!hit && rot[N-1-k]) begin
        hit = 1'b1;
        pos = k;
      end
    end
    src = int'(start) - pos;
    if (src < 0) src = src + N;
    if (hit) begin
      found   = 1'b1;
      idx     = W'(src);
      oh[src] = 1'b1;
    end
  end

endmodule

// File: rtl/prio_arbiter_n.sv
// Registered N-way priority arbiter with valid/ready output and optional round-robin rotation.
// Holds only the one-deep output register, the search pointer and the load logic.
module prio_arbiter_n
  import prio_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         grant_rdy,
  output logic         grant_vld,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_oh
);

  localparam logic [W-1:0] PTR_MAX = W'(N - 1);

  logic [W-1:0] ptr_q;
  logic [W-1:0] start;
  logic         load;
  logic         enc_found;
  logic [W-1:0] enc_idx;
  logic [N-1:0] enc_oh;

  assign load  = !grant_vld || grant_rdy;
  assign start = (mode == MODE_RR) ? ptr_q : PTR_MAX;

  prio_enc_rot #(.N(N), .W(W)) u_enc (
    .req   (req),
    .start (start),
    .found (enc_found),
    .idx   (enc_idx),
    .oh    (enc_oh)
  );

  // The encoder already returns zero index/one-hot when nothing is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld <= 1'b0;
      grant_idx <= '0;
      grant_oh  <= '0;
      ptr_q     <= PTR_MAX;
    end else if (load) begin
      grant_vld <= enc_found;
      grant_idx <= enc_idx;
      grant_oh  <= enc_oh;
      if (mode == MODE_FIXED) begin
        ptr_q <= PTR_MAX;
      end else if (enc_found) begin
        ptr_q <= W'(ptr_dec(int'(enc_idx), N));
      end
    end
  end

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Scoreboard bench for prio_arbiter_n: directed vectors on an N=8 and an N=6 instance.
// Stimulus queues expected grants; a negedge monitor pops and compares them one cycle later.
module tb_prio_arbiter_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req8;
  logic [5:0] req6;
  logic       mode;
  logic       grant_rdy;

  logic       vld8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic       vld6;
  logic [2:0] idx6;
  logic [5:0] oh6;

  typedef struct {
    bit         six;
    int         due;
    bit         vld;
    int         idx;
    logic [7:0] oh;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_ent;
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  prio_arbiter_n #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req8),
    .mode      (mode),
    .grant_rdy (grant_rdy),
    .grant_vld (vld8),
    .grant_idx (idx8),
    .grant_oh  (oh8)
  );

  prio_arbiter_n #(.N(6)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req6),
    .mode      (mode),
    .grant_rdy (grant_rdy),
    .grant_vld (vld6),
    .grant_idx (idx6),
    .grant_oh  (oh6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic act_vld, input int act_idx,
                             input logic [7:0] act_oh, input logic exp_vld, input int exp_idx,
                             input logic [7:0] exp_oh);
    n_checks++;
    if (act_vld === exp_vld && act_idx == exp_idx && act_oh === exp_oh) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got vld=%0b idx=%0d oh=%b, expected vld=%0b idx=%0d oh=%b",
               name, act_vld, act_idx, act_oh, exp_vld, exp_idx, exp_oh);
    end
  endtask

  // Drive one cycle of inputs and queue what the registered outputs must show after the next edge.
  task automatic applyStimulus(input bit six, input logic [7:0] r, input logic m, input logic rdy,
                               input logic ev, input int ei, input string name);
    exp_t ent;
    if (six) req6 = r[5:0];
    else     req8 = r;
    mode      = m;
    grant_rdy = rdy;
    ent.six  = six;
    ent.due  = cycle + 1;
    ent.vld  = ev;
    ent.idx  = ev ? ei : 0;
    ent.oh   = ev ? (8'd1 << ei) : 8'd0;
    ent.name = name;
    sb.push_back(ent);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      mon_ent = sb.pop_front();
      if (mon_ent.six)
        checkOutput(mon_ent.name, vld6, int'(idx6), {2'b00, oh6}, mon_ent.vld, mon_ent.idx, mon_ent.oh);
      else
        checkOutput(mon_ent.name, vld8, int'(idx8), oh8, mon_ent.vld, mon_ent.idx, mon_ent.oh);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    req8      = 8'h00;
    req6      = 6'h00;
    mode      = 1'b0;
    grant_rdy = 1'b1;

    // Reset must clear outputs asynchronously, before any clock edge.
    #1 rst_n = 1'b0;
    req8 = 8'hFF;
    #1;
    checkOutput("reset8", vld8, int'(idx8), oh8, 1'b0, 0, 8'h00);
    checkOutput("reset6", vld6, int'(idx6), {2'b00, oh6}, 1'b0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 8'hFF, 1'b0, 1'b1, 1'b1, 7, "rst_first");

    applyStimulus(0, 8'b11011101, 1'b0, 1'b1, 1'b1, 7, "fix_a");
    applyStimulus(0, 8'b00110100, 1'b0, 1'b1, 1'b1, 5, "fix_b");
    applyStimulus(0, 8'b00101000, 1'b0, 1'b1, 1'b1, 5, "fix_c");
    applyStimulus(0, 8'b00000000, 1'b0, 1'b1, 1'b0, 0, "fix_none");

    applyStimulus(0, 8'b10100001, 1'b1, 1'b1, 1'b1, 7, "rr_1");
    applyStimulus(0, 8'b10100001, 1'b1, 1'b1, 1'b1, 5, "rr_2");
    applyStimulus(0, 8'b10100001, 1'b1, 1'b1, 1'b1, 0, "rr_3");
    applyStimulus(0, 8'b10100001, 1'b1, 1'b1, 1'b1, 7, "rr_4");
    applyStimulus(0, 8'b10100001, 1'b1, 1'b1, 1'b1, 5, "rr_5");
    applyStimulus(0, 8'b10100001, 1'b1, 1'b1, 1'b1, 0, "rr_6");

    applyStimulus(0, 8'b10000000, 1'b0, 1'b1, 1'b1, 7, "bp_load");
    applyStimulus(0, 8'b00000010, 1'b0, 1'b0, 1'b1, 7, "bp_hold1");
    applyStimulus(0, 8'b00000010, 1'b0, 1'b0, 1'b1, 7, "bp_hold2");
    applyStimulus(0, 8'b00000010, 1'b0, 1'b0, 1'b1, 7, "bp_hold3");
    applyStimulus(0, 8'b00000010, 1'b0, 1'b1, 1'b1, 1, "bp_release");

    // The fixed-mode load in between rewrites the pointer to 7, so round-robin restarts from the top.
    applyStimulus(0, 8'b10000001, 1'b1, 1'b1, 1'b1, 7, "ms_rr");
    applyStimulus(0, 8'b10000001, 1'b0, 1'b1, 1'b1, 7, "ms_fixed");
    applyStimulus(0, 8'b10000001, 1'b1, 1'b1, 1'b1, 7, "ms_rr_again");
    applyStimulus(0, 8'b10000001, 1'b1, 1'b1, 1'b1, 0, "ms_rr_next");

    applyStimulus(0, 8'b00010001, 1'b1, 1'b1, 1'b1, 4, "rm_pre");
    grant_rdy = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid", vld8, int'(idx8), oh8, 1'b0, 0, 8'h00);
    #1 rst_n = 1'b1;
    applyStimulus(0, 8'b00010001, 1'b1, 1'b1, 1'b1, 4, "rm_post");

    applyStimulus(1, 8'b00100001, 1'b1, 1'b1, 1'b1, 5, "n6_rr1");
    applyStimulus(1, 8'b00100001, 1'b1, 1'b1, 1'b1, 0, "n6_rr2");
    applyStimulus(1, 8'b00100001, 1'b1, 1'b1, 1'b1, 5, "n6_rr3");
    applyStimulus(1, 8'b00011000, 1'b0, 1'b1, 1'b1, 4, "n6_fixed");
    applyStimulus(1, 8'b00000000, 1'b0, 1'b1, 1'b0, 0, "n6_none");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
